// File: rtl/log2_seq_if.sv
// Handshake bundle for log2_seq: operand channel (in_*) and result channel (out_*).
// LOG2_CEIL_EN adds the out_log2N_ceil result field.
interface log2_seq_if #(
  parameter int LOG2N_WIDTH = 5,
  parameter int N_WIDTH     = 32
);
  logic [N_WIDTH-1:0]     in_N;
  logic                   in_valid;
  logic                   in_ready;
  logic [LOG2N_WIDTH-1:0] out_log2N;
  logic                   out_is_pow2;
  logic                   out_zero;
  logic                   out_valid;
  logic                   out_ready;
`ifdef LOG2_CEIL_EN
  logic [LOG2N_WIDTH:0]   out_log2N_ceil;

  modport slave  (input  in_N, in_valid, out_ready,
                  output in_ready, out_log2N, out_is_pow2, out_zero, out_valid, out_log2N_ceil);
  modport master (output in_N, in_valid, out_ready,
                  input  in_ready, out_log2N, out_is_pow2, out_zero, out_valid, out_log2N_ceil);
`else
  modport slave  (input  in_N, in_valid, out_ready,
                  output in_ready, out_log2N, out_is_pow2, out_zero, out_valid);
  modport master (output in_N, in_valid, out_ready,
                  input  in_ready, out_log2N, out_is_pow2, out_zero, out_valid);
`endif
endinterface

// File: rtl/log2_seq.sv
// log2_seq: floor(log2(N)) by iterative binary search, LOG2N_WIDTH steps,
// fixed latency. Optional ceil(log2(N)) output when LOG2_CEIL_EN is defined.
module log2_seq #(
  parameter int LOG2N_WIDTH = 5,
  parameter int N_WIDTH     = 32
) (
  input  logic        clk,
  input  logic        rstn,
  log2_seq_if.slave   bus
);
  localparam int CW = LOG2N_WIDTH + 1;

  if (N_WIDTH > 2**LOG2N_WIDTH) begin : g_chk
    $error("log2_seq: N_WIDTH must be <= 2**LOG2N_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [N_WIDTH-1:0]     r_v;
  logic [LOG2N_WIDTH-1:0] r_r;
  logic [LOG2N_WIDTH-1:0] r_k;
  logic                   r_is_pow2, r_zero;
  logic [LOG2N_WIDTH-1:0] r_out_log2N;
  logic                   r_out_is_pow2, r_out_zero;

  logic                   w_accept, w_last, w_hit;
  logic [LOG2N_WIDTH-1:0] w_s;
  logic [N_WIDTH-1:0]     w_v_sh;
  logic [LOG2N_WIDTH-1:0] w_r_nxt;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode: accept in IDLE, count down in CALC, wait for consumer in DONE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: if (bus.in_valid) begin
              w_accept    = 1'b1;
              w_state_nxt = CALC;
            end
      CALC: if (r_k == '0) begin
              w_last      = 1'b1;
              w_state_nxt = DONE;
            end
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // One search step: try shifting by 2^k; shifts past the operand width give 0
  always_comb begin
    w_s    = LOG2N_WIDTH'(1) << r_k;
    w_v_sh = r_v >> w_s;
    if (int'(w_s) >= N_WIDTH) w_v_sh = '0;
    w_hit   = |w_v_sh;
    w_r_nxt = r_r;
    if (w_hit) w_r_nxt[r_k] = 1'b1;
  end

`ifdef LOG2_CEIL_EN
  logic [CW-1:0] r_out_ceil;
  logic [CW-1:0] w_ceil;

  // Ceil equals floor for exact powers of two and for zero, else floor+1
  always_comb begin
    w_ceil = {1'b0, w_r_nxt};
    if (!(r_is_pow2 || r_zero)) w_ceil = {1'b0, w_r_nxt} + CW'(1);
  end

  // Ceil result captured on entry to DONE alongside the floor result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        r_out_ceil <= '0;
    else if (r_state == CALC && w_last) r_out_ceil <= w_ceil;
  end

  assign bus.out_log2N_ceil = r_out_ceil;
`endif

  // Operand capture, search iteration, and result registers loaded on the last step
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v           <= '0;
      r_r           <= '0;
      r_k           <= '0;
      r_is_pow2     <= 1'b0;
      r_zero        <= 1'b0;
      r_out_log2N   <= '0;
      r_out_is_pow2 <= 1'b0;
      r_out_zero    <= 1'b0;
    end else if (w_accept) begin
      r_v       <= bus.in_N;
      r_r       <= '0;
      r_k       <= LOG2N_WIDTH'(LOG2N_WIDTH-1);
      r_is_pow2 <= (bus.in_N != '0) && ((bus.in_N & (bus.in_N - N_WIDTH'(1))) == '0);
      r_zero    <= (bus.in_N == '0);
    end else if (r_state == CALC) begin
      if (w_hit) r_v <= w_v_sh;
      r_r <= w_r_nxt;
      if (w_last) begin
        r_out_log2N   <= w_r_nxt;
        r_out_is_pow2 <= r_is_pow2;
        r_out_zero    <= r_zero;
      end else begin
        r_k <= r_k - LOG2N_WIDTH'(1);
      end
    end
  end

  // Handshake outputs decode straight from the state register
  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == DONE);
  assign bus.out_log2N   = r_out_log2N;
  assign bus.out_is_pow2 = r_out_is_pow2;
  assign bus.out_zero    = r_out_zero;

endmodule

// File: tb/tb_log2_seq.sv
// Directed bench for log2_seq: reset, value table, backpressure,
// back-to-back throughput and mid-calculation reset.
module tb_log2_seq;
  localparam int LW = 5;
  localparam int NW = 32;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   fails  = 0;

  log2_seq_if #(.LOG2N_WIDTH(LW), .N_WIDTH(NW)) bus ();

  log2_seq #(.LOG2N_WIDTH(LW), .N_WIDTH(NW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake one operand in; returns ok=0 if in_ready never came.
  task automatic start_op(input logic [NW-1:0] n, output bit ok);
    int w = 0;
    while (!bus.in_ready && w < 40) begin @(posedge clk); #1; w++; end
    ok = bus.in_ready;
    bus.in_N = n; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic ack;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus.in_N = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_log2N !== '0 ||
        bus.out_is_pow2 !== 1'b0 || bus.out_zero !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b log=%0d p2=%b z=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_log2N, bus.out_is_pow2, bus.out_zero);
    end
`ifdef LOG2_CEIL_EN
    checks++;
    if (bus.out_log2N_ceil !== '0) begin
      fails++; $display("FAIL reset_ceil: got %0d want 0", bus.out_log2N_ceil);
    end
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_values;
    logic [NW-1:0] vn [8] = '{32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1000,
                              32'd0, 32'd2, 32'd3, 32'h0001_0000};
    int            vl [8] = '{0, 31, 31, 9, 0, 1, 1, 16};
    bit            vp [8] = '{1, 1, 0, 0, 0, 1, 0, 1};
    bit            vz [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
    int            vc [8] = '{0, 31, 32, 10, 0, 1, 2, 16};
    bit ok; int lat;
    for (int i = 0; i < 8; i++) begin
      start_op(vn[i], ok);
      wait_result(lat);
      checks++;
      // Accept edge then LW CALC edges before DONE is visible.
      if (!ok || lat != LW) begin
        fails++; $display("FAIL latency[%0d]: got %0d want %0d", i, lat, LW);
      end
      checks++;
      if (bus.out_log2N !== vl[i][LW-1:0] || bus.out_is_pow2 !== vp[i] || bus.out_zero !== vz[i]) begin
        fails++;
        $display("FAIL value N=%h: log=%0d p2=%b z=%b want %0d %b %b",
                 vn[i], bus.out_log2N, bus.out_is_pow2, bus.out_zero, vl[i], vp[i], vz[i]);
      end
`ifdef LOG2_CEIL_EN
      checks++;
      if (bus.out_log2N_ceil !== vc[i][LW:0]) begin
        fails++; $display("FAIL ceil N=%h: got %0d want %0d", vn[i], bus.out_log2N_ceil, vc[i]);
      end
`else
      if (vc[i] < 0) $display("unexpected ceil table entry");
`endif
      ack();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        fails++; $display("FAIL release[%0d]: vld=%b rdy=%b want 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok; int lat; bit bad; bit leak;
    start_op(32'd1000, ok);
    wait_result(lat);
    checks++;
    if (!ok || lat != LW || bus.out_log2N !== 5'd9) begin
      fails++; $display("FAIL bp_first: lat=%0d log=%0d want %0d 9", lat, bus.out_log2N, LW);
    end
    bus.in_N = 32'd5; bus.in_valid = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.out_log2N !== 5'd9 || bus.out_is_pow2 !== 1'b0 ||
          bus.out_zero !== 1'b0 || bus.in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      fails++; $display("FAIL bp_hold: vld=%b log=%0d rdy=%b want 1 9 0",
                        bus.out_valid, bus.out_log2N, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    ack();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_log2N !== 5'd9) begin
      fails++; $display("FAIL bp_release: vld=%b rdy=%b log=%0d want 0 1 9",
                        bus.out_valid, bus.in_ready, bus.out_log2N);
    end
    leak = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) leak = 1'b1;
    end
    checks++;
    if (leak) begin
      fails++; $display("FAIL bp_no_queue: out_valid rose %b want 0", leak);
    end
  endtask

  task automatic test_back_to_back;
    logic [NW-1:0] ops [3] = '{32'd2, 32'd3, 32'd4};
    int exp_r [3] = '{1, 1, 2};
    int res [3]   = '{-1, -1, -1};
    int ts  [3]   = '{0, 0, 0};
    int idx = 0, got = 0, cyc = 0;
    bit acc;
    bus.out_ready = 1'b1;
    bus.in_N = ops[0]; bus.in_valid = 1'b1;
    while (got < 3 && cyc < 100) begin
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin res[got] = int'(bus.out_log2N); ts[got] = cyc; got++; end
      @(posedge clk); #1; cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) bus.in_N = ops[idx]; else bus.in_valid = 1'b0;
      end
    end
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    checks++;
    if (got != 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", got); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] != exp_r[i]) begin
        fails++; $display("FAIL b2b_value[%0d]: got %0d want %0d", i, res[i], exp_r[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (ts[i] - ts[i-1] != LW + 2) begin
        fails++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, ts[i] - ts[i-1], LW + 2);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    bit ok; int lat;
    start_op(32'd100, ok);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_log2N !== '0 || bus.out_is_pow2 !== 1'b0 ||
        bus.out_zero !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL midreset: vld=%b log=%0d p2=%b z=%b rdy=%b want 0 0 0 0 1",
                        bus.out_valid, bus.out_log2N, bus.out_is_pow2, bus.out_zero, bus.in_ready);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_discard: out_valid=%b want 0", bus.out_valid);
    end
    start_op(32'd64, ok);
    wait_result(lat);
    checks++;
    if (!ok || lat != LW || bus.out_log2N !== 5'd6 || bus.out_is_pow2 !== 1'b1 || bus.out_zero !== 1'b0) begin
      fails++; $display("FAIL after_reset: lat=%0d log=%0d p2=%b want %0d 6 1",
                        lat, bus.out_log2N, bus.out_is_pow2, LW);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
